// File: rtl/bus_dma_arbiter_pkg.sv
// Shared widths, bus addresses and sequencer state encoding for the
// sprite-DMA bus arbiter.
package bus_dma_arbiter_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  // A CPU write here starts a 256-byte page copy.
  localparam logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = 16'h4014;
  // Every copied byte is written to this fixed data port.
  localparam logic [ADDR_WIDTH-1:0] OAMDATA_ADDR  = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/bus_dma_arbiter_seq.sv
// DMA sequencer: state machine, byte index and free-running cycle parity.
// The parity flop lets HALT insert one ALIGN cycle so that every READ
// lands on an even cycle.
module bus_dma_arbiter_seq
  import bus_dma_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_trigger,
  output dma_state_e o_state,
  output logic [7:0] o_idx
);

  dma_state_e r_state;
  logic [7:0] r_idx;
  logic       r_cycle_odd;

  // Advance the copy sequence and toggle the cycle parity every clock.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 8'h00;
      r_cycle_odd <= 1'b0;
    end else begin
      r_cycle_odd <= ~r_cycle_odd;
      case (r_state)
        ST_IDLE: begin
          if (i_trigger) begin
            r_idx   <= 8'h00;
            r_state <= ST_HALT;
          end
        end
        ST_HALT:  r_state <= r_cycle_odd ? ST_READ : ST_ALIGN;
        ST_ALIGN: r_state <= ST_READ;
        ST_READ:  r_state <= ST_WRITE;
        ST_WRITE: begin
          r_idx   <= r_idx + 8'h01;
          r_state <= (r_idx == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_idx   = r_idx;

endmodule

// File: rtl/bus_dma_arbiter.sv
// Shared-bus arbiter between the CPU and a page-copy DMA engine.
// In IDLE the CPU owns the bus; a write to DMA_TRIG_ADDR halts the CPU
// and copies page {data,00..FF} to OAMDATA_ADDR one byte at a time.
module bus_dma_arbiter
  import bus_dma_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_we,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_dout,
  input  logic [REG_WIDTH-1:0]  bus_din,
  output logic                  bus_we,
  output logic                  dma_busy
);

  dma_state_e           w_state;
  logic [7:0]           w_idx;
  logic                 w_trigger;
  logic [7:0]           r_page;
  logic [REG_WIDTH-1:0] r_data;

  // Only a CPU write to the trigger address while idle starts a copy.
  assign w_trigger = (w_state == ST_IDLE) && cpu_we && (cpu_addr == DMA_TRIG_ADDR);

  bus_dma_arbiter_seq u_seq (
    .clk       (clk),
    .reset     (reset),
    .i_trigger (w_trigger),
    .o_state   (w_state),
    .o_idx     (w_idx)
  );

  // Capture the source page on trigger and the byte fetched in READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_page <= 8'h00;
      r_data <= '0;
    end else begin
      if (w_trigger) r_page <= cpu_dout;
      if (w_state == ST_READ) r_data <= bus_din;
    end
  end

  // Bus ownership mux, a pure function of the sequencer state.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = cpu_we;
    cpu_rdy  = 1'b0;
    dma_busy = 1'b1;
    case (w_state)
      ST_IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
      ST_HALT, ST_ALIGN: begin
        bus_dout = '0;
        bus_we   = 1'b0;
      end
      ST_READ: begin
        bus_addr = {r_page, w_idx};
        bus_dout = '0;
        bus_we   = 1'b0;
      end
      ST_WRITE: begin
        bus_addr = OAMDATA_ADDR;
        bus_dout = r_data;
        bus_we   = 1'b1;
      end
      default: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Self-checking bench for bus_dma_arbiter. The reference model tracks a
// transfer as "cycle k of an L-cycle halt" and derives the bus traffic of
// cycle k arithmetically.
module tb_bus_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_we;
  logic        dma_busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] salt;

  // Counters fed by the per-cycle sampler.
  int hc, rc, wc, any_w;

  // Reference model: m_k = cycle within the halt (-1 when idle).
  int         m_k;
  int         m_len;
  logic [7:0] m_page;
  logic       m_odd;

  always #5 clk = ~clk;

  bus_dma_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_we   (cpu_we),
    .cpu_rdy  (cpu_rdy),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_we   (bus_we),
    .dma_busy (dma_busy)
  );

  // Simulated memory contents: a salted hash of the address.
  function automatic logic [7:0] mem_f(input logic [15:0] a, input logic [7:0] s);
    logic [7:0] t;
    t = a[7:0] * 8'd29;
    return t ^ a[15:8] ^ s;
  endfunction

  assign bus_din = mem_f(bus_addr, salt);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k    <= -1;
      m_len  <= 0;
      m_page <= 8'h00;
      m_odd  <= 1'b0;
    end else begin
      if (m_k < 0) begin
        if (cpu_we && cpu_addr == 16'h4014) begin
          m_k    <= 0;
          m_len  <= m_odd ? 514 : 513;
          m_page <= cpu_dout;
        end
      end else begin
        m_k <= (m_k + 1 == m_len) ? -1 : m_k + 1;
      end
      m_odd <= ~m_odd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model for the current cycle.
  task automatic compare_all();
    logic [15:0] e_addr;
    logic [7:0]  e_dout, idx;
    logic        e_we, e_rdy, e_busy, chk_dout;
    int          al, j;
    e_addr = cpu_addr; e_dout = cpu_dout; e_we = cpu_we;
    e_rdy = 1'b1; e_busy = 1'b0; chk_dout = 1'b1;
    if (!reset && m_k >= 0) begin
      e_rdy = 1'b0; e_busy = 1'b1;
      al = (m_len == 514) ? 1 : 0;
      if (m_k < 1 + al) begin
        e_dout = 8'h00; e_we = 1'b0;
      end else begin
        j   = m_k - 1 - al;
        idx = 8'(j / 2);
        if (j % 2 == 0) begin
          e_addr = {m_page, idx}; e_we = 1'b0; chk_dout = 1'b0;
        end else begin
          e_addr = 16'h2004; e_we = 1'b1; e_dout = mem_f({m_page, idx}, salt);
        end
      end
    end
    check("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
    check("dma_busy", 32'(dma_busy), 32'(e_busy));
    check("bus_we", 32'(bus_we), 32'(e_we));
    check("bus_addr", 32'(bus_addr), 32'(e_addr));
    if (chk_dout) check("bus_dout", 32'(bus_dout), 32'(e_dout));
    if (cpu_rdy !== 1'b1) hc++;
    if (cpu_rdy !== 1'b1 && bus_we === 1'b1 && bus_addr == 16'h2004) wc++;
    if (cpu_rdy !== 1'b1 && bus_we === 1'b0 && bus_addr[15:8] == m_page && bus_addr != cpu_addr) rc++;
    if (bus_we === 1'b1 && bus_addr == 16'h2004) any_w++;
  endtask

  // One clock: entered at posedge+1, drives, samples mid-cycle, returns at posedge+1.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we, input logic rst);
    cpu_addr = a; cpu_dout = d; cpu_we = we; reset = rst;
    #4;
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(16'hFFFF, 8'h00, 1'b0, 1'b0);
  endtask

  // Run a triggered transfer until cpu_rdy returns, bounded.
  task automatic run_halt(input string tag, input int exp_len);
    hc = 0; rc = 0; wc = 0;
    for (int n = 0; n < 600 && cpu_rdy !== 1'b1; n++) idle_cycle();
    check({tag, "_halt_len"}, 32'(hc), 32'(exp_len));
    check({tag, "_reads"}, 32'(rc), 32'd256);
    check({tag, "_writes"}, 32'(wc), 32'd256);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_we;
  } vec_t;

  vec_t vecs[7];
  int   exp_len;

  initial begin
    salt = 8'($urandom);
    vecs[0] = '{16'h1234, 8'hAB, 1'b1, 16'h1234, 8'hAB, 1'b1};
    vecs[1] = '{16'h4015, 8'h02, 1'b1, 16'h4015, 8'h02, 1'b1};
    vecs[2] = '{16'h4014, 8'h02, 1'b0, 16'h4014, 8'h02, 1'b0};
    vecs[3] = '{16'h4013, 8'h55, 1'b1, 16'h4013, 8'h55, 1'b1};
    vecs[4] = '{16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[5] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1};
    vecs[6] = '{16'h2004, 8'h11, 1'b1, 16'h2004, 8'h11, 1'b1};

    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    drive(16'h1111, 8'h22, 1'b1, 1'b1);
    drive(16'h4014, 8'h33, 1'b1, 1'b1);
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_busy", 32'(dma_busy), 32'd0);

    // Idle pass-through vectors, none of which may trigger.
    for (int i = 0; i < 7; i++) begin
      cpu_addr = vecs[i].addr; cpu_dout = vecs[i].dout; cpu_we = vecs[i].we; reset = 1'b0;
      #4;
      check("vec_bus_addr", 32'(bus_addr), 32'(vecs[i].e_addr));
      check("vec_bus_dout", 32'(bus_dout), 32'(vecs[i].e_dout));
      check("vec_bus_we", 32'(bus_we), 32'(vecs[i].e_we));
      check("vec_rdy", 32'(cpu_rdy), 32'd1);
      @(posedge clk);
      #1;
      check("vec_busy_after", 32'(dma_busy), 32'd0);
    end

    // Trigger on an even cycle: no ALIGN.
    for (int n = 0; n < 2 && m_odd !== 1'b0; n++) idle_cycle();
    drive(16'h4014, 8'h02, 1'b1, 1'b0);
    run_halt("even", 513);

    // Trigger on an odd cycle: one ALIGN cycle.
    for (int n = 0; n < 2 && m_odd !== 1'b1; n++) idle_cycle();
    drive(16'h4014, 8'h02, 1'b1, 1'b0);
    run_halt("odd", 514);

    // Back-to-back: re-trigger in the first idle cycle after completion.
    drive(16'h4014, 8'h7E, 1'b1, 1'b0);
    exp_len = m_odd ? 514 : 513;
    run_halt("b2b_first", 513 + ((m_len == 514) ? 1 : 0));
    exp_len = m_odd ? 514 : 513;
    drive(16'h4014, 8'h03, 1'b1, 1'b0);
    run_halt("b2b_second", exp_len);

    // Abort after the 10th write, then restart from idx 0.
    drive(16'h4014, 8'h05, 1'b1, 1'b0);
    wc = 0;
    for (int n = 0; n < 40 && wc < 10; n++) idle_cycle();
    check("abort_writes_before", 32'(wc), 32'd10);
    cpu_we = 1'b0; reset = 1'b1;
    #1;
    check("abort_rdy", 32'(cpu_rdy), 32'd1);
    check("abort_busy", 32'(dma_busy), 32'd0);
    #3;
    @(posedge clk);
    #1;
    drive(16'hFFFF, 8'h00, 1'b0, 1'b1);
    any_w = 0;
    for (int n = 0; n < 20; n++) idle_cycle();
    check("abort_no_writes", 32'(any_w), 32'd0);
    exp_len = m_odd ? 514 : 513;
    drive(16'h4014, 8'h05, 1'b1, 1'b0);
    run_halt("restart", exp_len);

    // Randomized traffic with occasional resets, checked every cycle.
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        w, r;
      a = ($urandom_range(0, 5) == 0) ? 16'h4014 : 16'($urandom);
      d = 8'($urandom);
      w = 1'($urandom);
      r = ($urandom_range(0, 699) == 0);
      drive(a, d, w, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
